// File: rtl/gtfwizard_raw_drp_pkg.sv
// Shared DRP op codes, FSM states and watchdog default for the
// GTF common DRP master.
package gtfwizard_raw_drp_pkg;

  localparam logic [1:0] DRP_OP_READ  = 2'd0;
  localparam logic [1:0] DRP_OP_WRITE = 2'd1;
  localparam logic [1:0] DRP_OP_RMW   = 2'd2;

  localparam int unsigned DRP_TIMEOUT_CYC = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_EN,
    ST_RD_WAIT,
    ST_WR_EN,
    ST_WR_WAIT,
    ST_RESP
  } drp_state_t;

endpackage

// File: rtl/gtfwizard_raw_cm_drp_master.sv
// DRP initiator for the GTF common block: read, write and RMW.
// Define GTF_CM_DRP_TIMEOUT_EN to build in the drprdy watchdog.
module gtfwizard_raw_cm_drp_master
  import gtfwizard_raw_drp_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          DATA_W      = 16,
  parameter int unsigned TIMEOUT_CYC = DRP_TIMEOUT_CYC
) (
  input  logic              gtf_cm_drpclk,
  input  logic              gtf_cm_drprst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] cmd_mask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              gtf_cm_drpen,
  output logic              gtf_cm_drpwe,
  output logic [ADDR_W-1:0] gtf_cm_drpaddr,
  output logic [DATA_W-1:0] gtf_cm_drpdi,
  input  logic [DATA_W-1:0] gtf_cm_drpdo,
  input  logic              gtf_cm_drprdy
);

  drp_state_t        state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wr_q, wr_d;
  logic [DATA_W-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rd_q, rd_d;

`ifdef GTF_CM_DRP_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             to_hit;
  assign to_hit  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err = err_q;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC < 2);
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge gtf_cm_drpclk) begin
    if (gtf_cm_drprst) begin
      state_q <= ST_IDLE;
      op_q    <= DRP_OP_READ;
      addr_q  <= '0;
      wr_q    <= '0;
      mask_q  <= '0;
      rd_q    <= '0;
`ifdef GTF_CM_DRP_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      mask_q  <= mask_d;
      rd_q    <= rd_d;
`ifdef GTF_CM_DRP_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    mask_d  = mask_q;
    rd_d    = rd_q;
`ifdef GTF_CM_DRP_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          addr_d = cmd_addr;
          wr_d   = cmd_wdata;
          mask_d = cmd_mask;
          rd_d   = '0;
`ifdef GTF_CM_DRP_TIMEOUT_EN
          err_d  = 1'b0;
`endif
          state_d = (cmd_op == DRP_OP_WRITE) ? ST_WR_EN : ST_RD_EN;
        end
      end
      ST_RD_EN: begin
`ifdef GTF_CM_DRP_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (gtf_cm_drprdy) begin
          rd_d = gtf_cm_drpdo;
          if (op_q == DRP_OP_RMW) begin
            // Merge uses the live drpdo so the write can issue next cycle.
            wr_d    = (gtf_cm_drpdo & ~mask_q) | (wr_q & mask_q);
            state_d = ST_WR_EN;
          end else begin
            state_d = ST_RESP;
          end
        end
`ifdef GTF_CM_DRP_TIMEOUT_EN
        else if (to_hit) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_WR_EN: begin
`ifdef GTF_CM_DRP_TIMEOUT_EN
        cnt_d = '0;
`endif
        state_d = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (gtf_cm_drprdy) begin
          state_d = ST_RESP;
        end
`ifdef GTF_CM_DRP_TIMEOUT_EN
        else if (to_hit) begin
          rd_d    = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cmd_ready      = (state_q == ST_IDLE) & ~gtf_cm_drprst;
  assign rsp_valid      = (state_q == ST_RESP);
  assign rsp_data       = rd_q;
  assign gtf_cm_drpen   = (state_q == ST_RD_EN) | (state_q == ST_WR_EN);
  assign gtf_cm_drpwe   = (state_q == ST_WR_EN);
  assign gtf_cm_drpaddr = addr_q;
  assign gtf_cm_drpdi   = wr_q;

endmodule

// File: tb/tb_gtfwizard_raw_cm_drp_master.sv
// Directed bench: DRP responder model plus response scoreboard.
module tb_gtfwizard_raw_cm_drp_master;
  import gtfwizard_raw_drp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [15:0] cmd_mask = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [15:0] rsp_data;
  logic        rsp_err;
  logic        drpen, drpwe;
  logic [15:0] drpaddr, drpdi;
  logic [15:0] drpdo = 16'hDEAD;
  logic        drprdy = 1'b0;

  always #5 clk = ~clk;

  gtfwizard_raw_cm_drp_master #(
    .ADDR_W(16), .DATA_W(16), .TIMEOUT_CYC(16)
  ) dut (
    .gtf_cm_drpclk (clk),
    .gtf_cm_drprst (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_mask      (cmd_mask),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err),
    .gtf_cm_drpen  (drpen),
    .gtf_cm_drpwe  (drpwe),
    .gtf_cm_drpaddr(drpaddr),
    .gtf_cm_drpdi  (drpdi),
    .gtf_cm_drpdo  (drpdo),
    .gtf_cm_drprdy (drprdy)
  );

  typedef struct {
    logic [15:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] di;
  } stb_t;

  rsp_t        sb[$];
  stb_t        stb[$];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] mem [0:255];
  int          rdy_dly = 3;
  bit          no_rdy = 1'b0;
  bit          force_rdy = 1'b0;
  int          cnt = 0;
  logic [15:0] rdata = '0;
  int          n;
  int          n0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Responder: one strobe per drpen cycle, drprdy rdy_dly cycles later.
  always @(negedge clk) begin
    drprdy = force_rdy;
    drpdo  = 16'hDEAD;
    if (cnt != 0) begin
      cnt--;
      if (cnt == 0) begin
        drprdy = 1'b1;
        drpdo  = rdata;
      end
    end
    if (drpen) begin
      stb.push_back('{drpwe, drpaddr, drpdi});
      if (drpwe) mem[drpaddr[7:0]] = drpdi;
      rdata = mem[drpaddr[7:0]];
      if (!no_rdy) cnt = rdy_dly;
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        rsp_t e;
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic expect_rsp(logic [15:0] d, logic e);
    sb.push_back('{d, e});
  endtask

  task automatic send(logic [1:0] op, logic [15:0] a,
                      logic [15:0] wd, logic [15:0] m);
    int i;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_mask  = m;
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk("cmd_accept", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(negedge clk); #1;
    end
    chk("rsp_seen", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic lat(output int k);
    k = 0;
    while (!rsp_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[8'h08] = 16'h391C;
    mem[8'h10] = 16'h01E8;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_drpen", drpen, 0);
    chk("rst_drpwe", drpwe, 0);
    chk("rst_drpaddr", drpaddr, 0);
    chk("rst_drpdi", drpdi, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    @(posedge clk); #1;

    // READ
    stb.delete();
    expect_rsp(16'h391C, 1'b0);
    send(DRP_OP_READ, 16'h0008, 16'h0, 16'h0);
    wait_done();
    chk("rd_nstb", stb.size(), 1);
    chk("rd_we", stb[0].we, 0);
    chk("rd_addr", stb[0].addr, 16'h0008);

    // WRITE
    stb.delete();
    expect_rsp(16'h0000, 1'b0);
    send(DRP_OP_WRITE, 16'h0014, 16'h0F80, 16'h0);
    wait_done();
    chk("wr_nstb", stb.size(), 1);
    chk("wr_we", stb[0].we, 1);
    chk("wr_addr", stb[0].addr, 16'h0014);
    chk("wr_di", stb[0].di, 16'h0F80);

    // RMW
    stb.delete();
    expect_rsp(16'h01E8, 1'b0);
    send(DRP_OP_RMW, 16'h0010, 16'h2000, 16'hF000);
    wait_done();
    chk("rmw_nstb", stb.size(), 2);
    chk("rmw_rd_we", stb[0].we, 0);
    chk("rmw_wr_we", stb[1].we, 1);
    chk("rmw_wr_addr", stb[1].addr, 16'h0010);
    chk("rmw_wr_di", stb[1].di, 16'h21E8);

    // Reserved op behaves as READ
    stb.delete();
    expect_rsp(16'h0F80, 1'b0);
    send(2'd3, 16'h0014, 16'hFFFF, 16'hFFFF);
    wait_done();
    chk("rsv_nstb", stb.size(), 1);
    chk("rsv_we", stb[0].we, 0);

    // Minimum latencies
    rdy_dly = 1;
    expect_rsp(16'h21E8, 1'b0);
    send(DRP_OP_READ, 16'h0010, 16'h0, 16'h0);
    lat(n);
    chk("rd_min_lat", n, 3);
    wait_done();
    expect_rsp(16'h21E8, 1'b0);
    send(DRP_OP_RMW, 16'h0010, 16'h0, 16'h0);
    lat(n);
    chk("rmw_min_lat", n, 5);
    wait_done();
    rdy_dly = 3;

    // Backpressure with a competing command offered
    rsp_ready = 1'b0;
    expect_rsp(16'h391C, 1'b0);
    send(DRP_OP_READ, 16'h0008, 16'h0, 16'h0);
    lat(n);
    n0 = stb.size();
    cmd_valid = 1'b1;
    cmd_op    = DRP_OP_WRITE;
    cmd_addr  = 16'h0030;
    cmd_wdata = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'h391C);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_nstb", stb.size(), n0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_done();
    chk("bp_no_write", mem[8'h30], 16'h0000);

    // Reset during RD_WAIT, stray drprdy afterwards
    rdy_dly = 8;
    send(DRP_OP_READ, 16'h0008, 16'h0, 16'h0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_drpen", drpen, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_addr", drpaddr, 0);
    chk("mid_rst_data", rsp_data, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("stray_no_valid", rsp_valid, 0);
    chk("stray_ready", cmd_ready, 1);
    @(posedge clk); #1;
    rdy_dly = 3;
    stb.delete();
    expect_rsp(16'h0F80, 1'b0);
    send(DRP_OP_READ, 16'h0014, 16'h0, 16'h0);
    wait_done();
    chk("after_rst_nstb", stb.size(), 1);

`ifdef GTF_CM_DRP_TIMEOUT_EN
    no_rdy = 1'b1;
    expect_rsp(16'h0000, 1'b1);
    send(DRP_OP_READ, 16'h0008, 16'h0, 16'h0);
    lat(n);
    chk("to_lat", n, 18);
    wait_done();
    force_rdy = 1'b1;
    repeat (2) @(negedge clk);
    force_rdy = 1'b0;
    repeat (3) @(negedge clk);
    chk("to_late_rdy", rsp_valid, 0);
    @(posedge clk); #1;
    stb.delete();
    expect_rsp(16'h0000, 1'b1);
    send(DRP_OP_RMW, 16'h0010, 16'hFFFF, 16'hFFFF);
    wait_done();
    chk("to_rmw_nstb", stb.size(), 1);
    no_rdy = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtfwizard_raw_cm_drp_master.md
# gtfwizard_raw_cm_drp_master

DRP initiator that drives the DRP port of the GTF common (QPLL) block from a simple command/response handshake. It serialises read, write and read-modify-write (RMW) accesses, generates single-cycle `drpen`/`drpwe` strobes and waits for `drprdy`. An optional watchdog bounds the wait. The block sits between the example design's control/AXI-lite bridge and the common wrapper's `gtf_cm_drp*` pins, in the `gtf_cm_drpclk` domain.

## Interface
- `ADDR_W`, 16: DRP address width.
- `DATA_W`, 16: DRP data width.
- `TIMEOUT_CYC`, 1024: cycles to wait for `drprdy` before error. Used only when the watchdog is compiled in. Must be ≥ 2.
- `gtf_cm_drpclk`  in  1  DRP clock; all logic is on its rising edge.
- `gtf_cm_drprst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_op`  in  2  0 = READ, 1 = WRITE, 2 = RMW, 3 = reserved (treated as READ).
- `cmd_addr`  in  ADDR_W  DRP address.
- `cmd_wdata`  in  DATA_W  write data.
- `cmd_mask`  in  DATA_W  RMW bit mask; 1 = take bit from `cmd_wdata`.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  DATA_W  read data. For RMW this is the pre-modify value; for WRITE it is 0.
- `rsp_err`  out  1  access timed out.
- `gtf_cm_drpen`  out  1  DRP enable strobe.
- `gtf_cm_drpwe`  out  1  DRP write enable.
- `gtf_cm_drpaddr`  out  ADDR_W  DRP address.
- `gtf_cm_drpdi`  out  DATA_W  DRP write data.
- `gtf_cm_drpdo`  in  DATA_W  DRP read data.
- `gtf_cm_drprdy`  in  1  DRP completion.

## Operation
- **States:** IDLE, RD_EN, RD_WAIT, WR_EN, WR_WAIT, RESP.
- **IDLE:** `cmd_ready`=1. On `cmd_valid & cmd_ready`, latch op, addr, wdata and mask.
  - READ or RMW → RD_EN.
  - WRITE → WR_EN.
- **RD_EN:** `drpen`=1, `drpwe`=0 for one cycle → RD_WAIT.
- **RD_WAIT:** on `drprdy`, capture `drpdo` into the read register.
  - READ → RESP.
  - RMW → compute `(drpdo & ~mask) | (wdata & mask)` into the write register → WR_EN.
- **WR_EN:** `drpen`=1, `drpwe`=1, `drpdi` = write register, for one cycle → WR_WAIT.
- **WR_WAIT:** on `drprdy` → RESP.
- **RESP:** `rsp_valid`=1, `rsp_data`/`rsp_err` held stable until `rsp_ready`, then → IDLE.
- **Ignored `drprdy`:** `drprdy` is ignored in IDLE, in the RD_EN/WR_EN cycles, and in RESP. This covers stray and late completions.
- **Output holding:** `drpaddr` and `drpdi` hold their last values outside strobes. The DRP port only samples them with `drpen`.
- **Reserved op:** `cmd_op`=3 behaves exactly as READ.

## Timing
- **Reset values:** `cmd_ready`=0 during reset and 1 in the first cycle after. `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `drpen`=0, `drpwe`=0, `drpaddr`=0, `drpdi`=0.
- **Command to strobe:** command accepted at edge N → `drpen` high for cycle N+1 only. `drprdy` is sampled from cycle N+2.
- **Read latency:** `drprdy` seen at edge M → `rsp_valid` from cycle M+1. READ minimum is accept+3 cycles.
- **RMW latency:** the write strobe is in the cycle after read `drprdy`. Minimum is accept+5 cycles to `rsp_valid`.
- **Throughput:** one outstanding access. `cmd_ready`=0 from acceptance until the cycle after the `rsp_valid & rsp_ready` handshake.
- **Back-to-back:** `rsp_ready` tied high gives one response per access.
- **Reset mid-operation:** the next edge returns to IDLE, drops the strobes and discards any pending response. A later `drprdy` is ignored.

## Configuration
- Macro: `GTF_CM_DRP_TIMEOUT_EN`.
- **Defined:**
  - A wait counter clears on entry to RD_WAIT or WR_WAIT and increments each cycle without `drprdy`.
  - Reaching `TIMEOUT_CYC` → RESP with `rsp_err`=1 and `rsp_data`=0.
  - An RMW whose read phase times out does not issue its write.
  - `drprdy` in the same cycle the counter hits its limit counts as success.
- **Undefined:** no counter. The block waits indefinitely and `rsp_err` is constant 0.

## Structure
- Package `gtfwizard_raw_drp_pkg`:
  - op encoding constants: `DRP_OP_READ`, `DRP_OP_WRITE`, `DRP_OP_RMW`;
  - FSM state enum `drp_state_t`;
  - default `DRP_TIMEOUT_CYC`.
- Single module. The watchdog is an inline counter; no sub-module.

## Test plan
- **READ:** addr 0x0008, responder returns 0x391C with `drprdy` 3 cycles after `drpen` → exactly one `drpen` with `drpwe`=0 and `drpaddr`=0x0008; response `rsp_data`=0x391C, `rsp_err`=0.
- **WRITE:** addr 0x0014, data 0x0F80 → one `drpen` with `drpwe`=1 and `drpdi`=0x0F80; `rsp_data`=0.
- **RMW:** current 0x01E8, wdata 0x2000, mask 0xF000 → write `drpdi`=0x21E8; `rsp_data`=0x01E8; exactly two strobes.
- **Backpressure:** `rsp_ready` held 0 for 10 cycles → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, no new strobe until the handshake.
- **Timeout (macro defined):** `TIMEOUT_CYC`=16, `drprdy` never asserted → `rsp_err`=1 at wait cycle 16; a late `drprdy` is ignored; an RMW issues no write.
- **Reset during RD_WAIT, then stray `drprdy`:** all outputs return to reset values; no `rsp_valid`; the next READ completes normally.
